// File: rtl/decode_issue.sv
// RV32I decode/issue stage: decodes one instruction per cycle into the ID/EX register
// feeding the ALU, with load-use bubble insertion, stall hold and flush.
module decode_issue #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic            ex_valid,
    input  logic            ex_ready,
    output logic [4:0]      ex_alu_op,
    output logic [XLEN-1:0] ex_alu_in1,
    output logic [XLEN-1:0] ex_alu_in2,
    output logic [2:0]      ex_funct3,
    output logic [XLEN-1:0] ex_rs2_data,
    output logic [XLEN-1:0] ex_imm,
    output logic [XLEN-1:0] ex_pc,
    output logic [4:0]      ex_rd,
    output logic            ex_reg_write,
    output logic            ex_mem_read,
    output logic            ex_mem_write,
    output logic            ex_branch,
    output logic            ex_jal,
    output logic            ex_jalr,
    output logic            ex_illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_SLL  = 5'd2;
    localparam logic [4:0] ALU_SLT  = 5'd3;
    localparam logic [4:0] ALU_SLTU = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_OR   = 5'd8;
    localparam logic [4:0] ALU_AND  = 5'd9;

    function automatic logic [4:0] alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    logic [6:0]      w_opcode;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic [4:0]      w_rd;
    logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_u, w_imm_j, w_shamt;
    logic [4:0]      w_alu_op;
    logic [XLEN-1:0] w_in1, w_in2, w_imm, w_st_data;
    logic            w_rw, w_mr, w_mw, w_br, w_jal, w_jalr, w_ill;
    logic            w_rs1_used, w_rs2_used, w_hazard, w_xfer;

    logic            r_valid;
    logic [4:0]      r_alu_op;
    logic [XLEN-1:0] r_in1, r_in2, r_rs2_data, r_imm, r_pc;
    logic [2:0]      r_f3;
    logic [4:0]      r_rd;
    logic            r_rw, r_mr, r_mw, r_br, r_jal, r_jalr, r_ill;

    assign w_opcode = in_instr[6:0];
    assign w_f3     = in_instr[14:12];
    assign w_f7     = in_instr[31:25];
    assign w_rd     = in_instr[11:7];
    assign rs1_addr = in_instr[19:15];
    assign rs2_addr = in_instr[24:20];

    assign w_imm_i = XLEN'(signed'(in_instr[31:20]));
    assign w_imm_s = XLEN'(signed'({in_instr[31:25], in_instr[11:7]}));
    assign w_imm_b = XLEN'(signed'({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
    assign w_imm_u = XLEN'(signed'({in_instr[31:12], 12'b0}));
    assign w_imm_j = XLEN'(signed'({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));
    assign w_shamt = XLEN'(in_instr[24:20]);

    always_comb begin
        w_alu_op   = ALU_ADD;
        w_in1      = rs1_data;
        w_in2      = rs2_data;
        w_imm      = '0;
        w_st_data  = rs2_data;
        w_rw       = 1'b0;
        w_mr       = 1'b0;
        w_mw       = 1'b0;
        w_br       = 1'b0;
        w_jal      = 1'b0;
        w_jalr     = 1'b0;
        w_ill      = 1'b0;
        w_rs1_used = 1'b0;
        w_rs2_used = 1'b0;
        case (w_opcode)
            OPC_OP: begin
                w_rs1_used = 1'b1;
                w_rs2_used = 1'b1;
                w_rw       = 1'b1;
                w_alu_op   = alu_from_f3(w_f3, in_instr[30]);
                w_ill      = !((w_f7 == 7'b0000000) ||
                               (w_f7 == 7'b0100000 && (w_f3 == 3'b000 || w_f3 == 3'b101)));
            end
            OPC_OP_IMM: begin
                w_rs1_used = 1'b1;
                w_rw       = 1'b1;
                w_alu_op   = alu_from_f3(w_f3, (w_f3 == 3'b101) & in_instr[30]);
                // shifts take the 5-bit shamt, not the sign-extended 12-bit field
                if (w_f3 == 3'b001 || w_f3 == 3'b101) begin
                    w_in2 = w_shamt;
                    w_imm = w_shamt;
                    w_ill = (w_f3 == 3'b001) ? (w_f7 != 7'b0000000)
                                             : !(w_f7 == 7'b0000000 || w_f7 == 7'b0100000);
                end else begin
                    w_in2 = w_imm_i;
                    w_imm = w_imm_i;
                end
            end
            OPC_LOAD: begin
                w_rs1_used = 1'b1;
                w_rw       = 1'b1;
                w_mr       = 1'b1;
                w_in2      = w_imm_i;
                w_imm      = w_imm_i;
                w_ill      = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
            end
            OPC_STORE: begin
                w_rs1_used = 1'b1;
                w_rs2_used = 1'b1;
                w_mw       = 1'b1;
                w_in2      = w_imm_s;
                w_imm      = w_imm_s;
                w_ill      = w_f3[2] || (w_f3 == 3'b011);
            end
            OPC_BRANCH: begin
                w_rs1_used = 1'b1;
                w_rs2_used = 1'b1;
                w_br       = 1'b1;
                w_imm      = w_imm_b;
                case (w_f3[2:1])
                    2'b00:   w_alu_op = ALU_XOR;
                    2'b10:   w_alu_op = ALU_SLT;
                    2'b11:   w_alu_op = ALU_SLTU;
                    default: w_ill    = 1'b1;
                endcase
            end
            OPC_LUI: begin
                w_rw  = 1'b1;
                w_in1 = '0;
                w_in2 = w_imm_u;
                w_imm = w_imm_u;
            end
            OPC_AUIPC: begin
                w_rw  = 1'b1;
                w_in1 = in_pc;
                w_in2 = w_imm_u;
                w_imm = w_imm_u;
            end
            OPC_JAL: begin
                w_rw  = 1'b1;
                w_jal = 1'b1;
                w_in1 = in_pc;
                w_in2 = XLEN'(4);
                w_imm = w_imm_j;
            end
            OPC_JALR: begin
                w_rs1_used = 1'b1;
                w_rw       = 1'b1;
                w_jalr     = 1'b1;
                w_in1      = in_pc;
                w_in2      = XLEN'(4);
                w_imm      = w_imm_i;
                w_st_data  = rs1_data;
                w_ill      = (w_f3 != 3'b000);
            end
            default: w_ill = 1'b1;
        endcase
        // an illegal instruction must have no architectural side effects downstream
        if (w_ill) begin
            w_rw   = 1'b0;
            w_mr   = 1'b0;
            w_mw   = 1'b0;
            w_br   = 1'b0;
            w_jal  = 1'b0;
            w_jalr = 1'b0;
        end
        if (w_rd == 5'd0) w_rw = 1'b0;
    end

    assign w_hazard = r_valid && r_mr && (r_rd != 5'd0) &&
                      ((w_rs1_used && (r_rd == rs1_addr)) || (w_rs2_used && (r_rd == rs2_addr)));
    assign in_ready = !rst && !flush && !w_hazard && (!r_valid || ex_ready);
    assign w_xfer   = in_valid && in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_alu_op   <= '0;
            r_in1      <= '0;
            r_in2      <= '0;
            r_f3       <= '0;
            r_rs2_data <= '0;
            r_imm      <= '0;
            r_pc       <= RESET_PC;
            r_rd       <= '0;
            r_rw       <= 1'b0;
            r_mr       <= 1'b0;
            r_mw       <= 1'b0;
            r_br       <= 1'b0;
            r_jal      <= 1'b0;
            r_jalr     <= 1'b0;
            r_ill      <= 1'b0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_xfer) begin
            r_valid    <= 1'b1;
            r_alu_op   <= w_alu_op;
            r_in1      <= w_in1;
            r_in2      <= w_in2;
            r_f3       <= w_f3;
            r_rs2_data <= w_st_data;
            r_imm      <= w_imm;
            r_pc       <= in_pc;
            r_rd       <= w_rd;
            r_rw       <= w_rw;
            r_mr       <= w_mr;
            r_mw       <= w_mw;
            r_br       <= w_br;
            r_jal      <= w_jal;
            r_jalr     <= w_jalr;
            r_ill      <= w_ill;
        end else if (ex_ready) begin
            // covers both the load-use bubble and plain drain
            r_valid <= 1'b0;
        end
    end

    assign ex_valid     = r_valid;
    assign ex_alu_op    = r_alu_op;
    assign ex_alu_in1   = r_in1;
    assign ex_alu_in2   = r_in2;
    assign ex_funct3    = r_f3;
    assign ex_rs2_data  = r_rs2_data;
    assign ex_imm       = r_imm;
    assign ex_pc        = r_pc;
    assign ex_rd        = r_rd;
    assign ex_reg_write = r_rw;
    assign ex_mem_read  = r_mr;
    assign ex_mem_write = r_mw;
    assign ex_branch    = r_br;
    assign ex_jal       = r_jal;
    assign ex_jalr      = r_jalr;
    assign ex_illegal   = r_ill;

endmodule

// File: tb/tb_decode_issue.sv
// Scoreboard bench for decode_issue: driver queues expected ID/EX contents on acceptance,
// a negedge monitor pops and compares whenever execute consumes an instruction.
module tb_decode_issue;

    localparam logic [31:0] RST_PC = 32'h0000_0040;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, flush, ex_valid, ex_ready;
    logic [31:0] in_instr, in_pc, rs1_data, rs2_data;
    logic [4:0]  rs1_addr, rs2_addr;
    logic [4:0]  ex_alu_op, ex_rd;
    logic [31:0] ex_alu_in1, ex_alu_in2, ex_rs2_data, ex_imm, ex_pc;
    logic [2:0]  ex_funct3;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jal, ex_jalr, ex_illegal;

    decode_issue #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_alu_op(ex_alu_op),
        .ex_alu_in1(ex_alu_in1), .ex_alu_in2(ex_alu_in2), .ex_funct3(ex_funct3),
        .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_pc(ex_pc), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .ex_branch(ex_branch), .ex_jal(ex_jal), .ex_jalr(ex_jalr), .ex_illegal(ex_illegal)
    );

    always #5 clk = ~clk;

    // flags: {reg_write, mem_read, mem_write, branch, jal, jalr, illegal}
    typedef struct packed {
        logic [4:0]  alu_op;
        logic [31:0] in1;
        logic [31:0] in2;
        logic [2:0]  f3;
        logic [31:0] rs2d;
        logic [31:0] imm;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [6:0]  flags;
    } exp_t;

    // mask bits: [0] imm, [1] alu_op/in1/in2, [2] rd, [3] rs2_data
    typedef struct {
        exp_t       ex;
        logic [3:0] m;
        int         id;
    } sb_t;

    localparam logic [6:0] F_RW  = 7'b1000000;
    localparam logic [6:0] F_MR  = 7'b0100000;
    localparam logic [6:0] F_BR  = 7'b0001000;
    localparam logic [6:0] F_JAL = 7'b0000100;
    localparam logic [6:0] F_ILL = 7'b0000001;

    sb_t  q[$];
    sb_t  s_mon;
    int   n_vec = 0;
    int   n_miss = 0;
    int   vid = 0;
    exp_t e_or;

    function automatic exp_t mk(input logic [4:0] a, input logic [31:0] i1, input logic [31:0] i2,
                                input logic [2:0] f3, input logic [31:0] d2, input logic [31:0] imm,
                                input logic [31:0] pc, input logic [4:0] rd, input logic [6:0] fl);
        exp_t e;
        e.alu_op = a; e.in1 = i1; e.in2 = i2; e.f3 = f3; e.rs2d = d2;
        e.imm = imm; e.pc = pc; e.rd = rd; e.flags = fl;
        return e;
    endfunction

    task automatic check_ex(input string name, input exp_t e, input logic [3:0] m);
        exp_t act;
        act = {ex_alu_op, ex_alu_in1, ex_alu_in2, ex_funct3, ex_rs2_data, ex_imm, ex_pc, ex_rd,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jal, ex_jalr, ex_illegal};
        if (!m[0]) act.imm = e.imm;
        if (!m[1]) begin act.alu_op = e.alu_op; act.in1 = e.in1; act.in2 = e.in2; end
        if (!m[2]) act.rd = e.rd;
        if (!m[3]) act.rs2d = e.rs2d;
        n_vec++;
        if (act !== e) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, e);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check_reset(input string name);
        logic [180:0] act, exp;
        act = {ex_valid, ex_alu_op, ex_alu_in1, ex_alu_in2, ex_funct3, ex_rs2_data, ex_imm, ex_rd,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_jal, ex_jalr, ex_illegal, ex_pc};
        exp = '0;
        exp[31:0] = RST_PC;
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // offer an instruction, wait for acceptance, then queue its expected ID/EX contents
    task automatic send(input logic [31:0] ins, input logic [31:0] pc, input logic [31:0] d1,
                        input logic [31:0] d2, input bit push, input exp_t ex,
                        input logic [3:0] m, input int exp_wait);
        int w;
        bit ok;
        w = 0;
        ok = 1'b0;
        in_valid = 1'b1; in_instr = ins; in_pc = pc; rs1_data = d1; rs2_data = d2;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (in_ready) begin ok = 1'b1; break; end
            w++;
        end
        if (!ok) begin
            n_vec++; n_miss++;
            $display("FAIL accept_%0d: got no in_ready in 16 cycles, expected acceptance", vid);
            in_valid = 1'b0;
        end else begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            if (push) q.push_back('{ex: ex, m: m, id: vid});
            chk($sformatf("wait_cycles_%0d", vid), w, exp_wait);
        end
        vid++;
    endtask

    always @(negedge clk) begin
        if (!rst && ex_valid && ex_ready) begin
            if (q.size() == 0) begin
                n_vec++; n_miss++;
                $display("FAIL unexpected_issue: got pc %h, expected no instruction", ex_pc);
            end else begin
                s_mon = q.pop_front();
                check_ex($sformatf("issue_%0d", s_mon.id), s_mon.ex, s_mon.m);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0;
        rs1_data = '0; rs2_data = '0; flush = 1'b0; ex_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset("reset_state");
        @(posedge clk); #1;

        // back-to-back issue with execute always ready
        send(32'h002081B3, 32'h000, 32'd5, 32'd7, 1, mk(0, 5, 7, 0, 7, 0, 32'h000, 3, F_RW), 4'b1110, 0);
        send(32'h402081B3, 32'h004, 32'd5, 32'd7, 1, mk(1, 5, 7, 0, 7, 0, 32'h004, 3, F_RW), 4'b1110, 0);
        send(32'h40335293, 32'h008, 32'h8000_0000, 32'h11, 1,
             mk(7, 32'h8000_0000, 3, 5, 32'h11, 0, 32'h008, 5, F_RW), 4'b1110, 0);
        send(32'h123450B7, 32'h00C, 32'hAA, 32'hBB, 1,
             mk(0, 0, 32'h1234_5000, 5, 0, 32'h1234_5000, 32'h00C, 1, F_RW), 4'b0111, 0);
        send(32'h008000EF, 32'h100, 32'hAA, 32'hBB, 1,
             mk(0, 32'h100, 4, 0, 0, 8, 32'h100, 1, F_RW | F_JAL), 4'b0111, 0);
        send(32'hFE20EEE3, 32'h104, 32'd3, 32'd9, 1,
             mk(4, 3, 9, 6, 9, 32'hFFFF_FFFC, 32'h104, 0, F_BR), 4'b1011, 0);
        send(32'h00208463, 32'h108, 32'h55, 32'h55, 1,
             mk(5, 32'h55, 32'h55, 0, 32'h55, 8, 32'h108, 0, F_BR), 4'b1011, 0);
        // load-use: exactly one bubble before the dependent add
        send(32'h0000A203, 32'h10C, 32'h1000, 32'h77, 1,
             mk(0, 32'h1000, 0, 2, 0, 0, 32'h10C, 4, F_RW | F_MR), 4'b0111, 0);
        send(32'h004202B3, 32'h110, 32'h20, 32'h20, 1,
             mk(0, 32'h20, 32'h20, 0, 32'h20, 0, 32'h110, 5, F_RW), 4'b1110, 1);
        send(32'h0000A203, 32'h114, 32'h2000, 32'h77, 1,
             mk(0, 32'h2000, 0, 2, 0, 0, 32'h114, 4, F_RW | F_MR), 4'b0111, 0);
        send(32'h000002B3, 32'h118, 32'h0, 32'h0, 1, mk(0, 0, 0, 0, 0, 0, 32'h118, 5, F_RW), 4'b1110, 0);
        send(32'h000000FF, 32'h11C, 32'd1, 32'd2, 1, mk(0, 0, 0, 0, 0, 0, 32'h11C, 1, F_ILL), 4'b0100, 0);
        send(32'h00100013, 32'h120, 32'h0, 32'h33, 1, mk(0, 0, 1, 0, 0, 1, 32'h120, 0, 7'b0), 4'b0111, 0);
        repeat (3) @(posedge clk); #1;

        // stall: held instruction stays put and nothing new is accepted
        ex_ready = 1'b0;
        e_or = mk(8, 32'hF0, 32'h0F, 6, 32'h0F, 0, 32'h200, 6, F_RW);
        send(32'h0020E333, 32'h200, 32'hF0, 32'h0F, 1, e_or, 4'b1110, 0);
        in_valid = 1'b1; in_instr = 32'h00F0F393; in_pc = 32'h204;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_ex($sformatf("stall_hold_%0d", c), e_or, 4'b1110);
            chk($sformatf("stall_in_ready_%0d", c), {31'b0, in_ready}, 32'd0);
            chk($sformatf("stall_valid_%0d", c), {31'b0, ex_valid}, 32'd1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; ex_ready = 1'b1;
        repeat (2) @(posedge clk); #1;

        // flush during stall kills the held instruction and refuses the offered one
        ex_ready = 1'b0;
        send(32'h402081B3, 32'h208, 32'd1, 32'd1, 0, '0, 4'b0, 0);
        in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h20C; flush = 1'b1;
        @(negedge clk);
        chk("flush_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_kill", {31'b0, ex_valid}, 32'd0);
        @(posedge clk); #1;
        ex_ready = 1'b1;
        @(negedge clk);
        chk("flush_no_accept", {31'b0, ex_valid}, 32'd0);
        @(posedge clk); #1;

        // reset during a stall with a load-use candidate on the input
        ex_ready = 1'b0;
        send(32'h0000A203, 32'h210, 32'h3000, 32'h0, 0, '0, 4'b0, 0);
        in_valid = 1'b1; in_instr = 32'h004202B3; in_pc = 32'h214; rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check_reset("rst_mid_state");
        @(posedge clk); #1;
        ex_ready = 1'b1;
        send(32'h002081B3, 32'h300, 32'd1, 32'd2, 1, mk(0, 1, 2, 0, 2, 0, 32'h300, 3, F_RW), 4'b1110, 0);
        repeat (3) @(posedge clk); #1;

        chk("scoreboard_empty", q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
